// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor split into STAGES chunks, with carry/ovf/zero/neg flags.
// Define ADDSUB_SAT_EN to add the in_sat port for signed saturation on overflow.
module pipelined_add_sub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
`ifdef ADDSUB_SAT_EN
    input  logic             in_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if ((WIDTH % STAGES) != 0) begin : g_badParams
        $error("pipelined_add_sub: WIDTH must be a multiple of STAGES");
    end

    logic             r_valid [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic [WIDTH-1:0] r_sum   [STAGES];
    logic             r_carry [STAGES];
    logic             r_zero  [STAGES];
    logic             r_ovf;
`ifdef ADDSUB_SAT_EN
    logic             r_sat   [STAGES];
    logic             w_satIn [STAGES];
`endif

    logic             w_vIn     [STAGES];
    logic [WIDTH-1:0] w_aIn     [STAGES];
    logic [WIDTH-1:0] w_bIn     [STAGES];
    logic [WIDTH-1:0] w_sumIn   [STAGES];
    logic             w_cIn     [STAGES];
    logic             w_zeroIn  [STAGES];
    logic [CW:0]      w_chunk   [STAGES];
    logic [WIDTH-1:0] w_sumNext [STAGES];
    logic             w_zeroNext[STAGES];
    logic             w_msbCin;
    logic             w_ovf;
    logic [WIDTH-1:0] w_sumFinal;
    logic             w_zeroFinal;
    logic             w_advance;

    assign w_advance = !r_valid[LAST] || out_ready;
    assign in_ready  = w_advance;

    // Stage 0 takes the fresh operands (B inverted, carry forced for subtract);
    // later stages take the skewed operands and partial sum from the previous register.
    always_comb begin
        w_vIn[0]    = in_valid;
        w_aIn[0]    = in_a;
        w_bIn[0]    = in_sub ? ~in_b : in_b;
        w_cIn[0]    = in_sub ? 1'b1 : in_cin;
        w_sumIn[0]  = '0;
        w_zeroIn[0] = 1'b1;
`ifdef ADDSUB_SAT_EN
        w_satIn[0]  = in_sat;
`endif
        for (int k = 1; k < STAGES; k++) begin
            w_vIn[k]    = r_valid[k-1];
            w_aIn[k]    = r_a[k-1];
            w_bIn[k]    = r_b[k-1];
            w_cIn[k]    = r_carry[k-1];
            w_sumIn[k]  = r_sum[k-1];
            w_zeroIn[k] = r_zero[k-1];
`ifdef ADDSUB_SAT_EN
            w_satIn[k]  = r_sat[k-1];
`endif
        end
        for (int k = 0; k < STAGES; k++) begin
            w_chunk[k] = {1'b0, w_aIn[k][k*CW +: CW]} + {1'b0, w_bIn[k][k*CW +: CW]}
                       + {{CW{1'b0}}, w_cIn[k]};
            w_sumNext[k] = w_sumIn[k];
            w_sumNext[k][k*CW +: CW] = w_chunk[k][CW-1:0];
            w_zeroNext[k] = w_zeroIn[k] && (w_chunk[k][CW-1:0] == '0);
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
    always_comb begin
        w_msbCin    = w_sumNext[LAST][WIDTH-1] ^ w_aIn[LAST][WIDTH-1] ^ w_bIn[LAST][WIDTH-1];
        w_ovf       = w_chunk[LAST][CW] ^ w_msbCin;
        w_sumFinal  = w_sumNext[LAST];
        w_zeroFinal = w_zeroNext[LAST];
`ifdef ADDSUB_SAT_EN
        if (w_satIn[LAST] && w_ovf) begin
            w_sumFinal  = {w_aIn[LAST][WIDTH-1], {(WIDTH-1){~w_aIn[LAST][WIDTH-1]}}};
            w_zeroFinal = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
            end
        end else if (w_advance) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= w_vIn[k];
                r_a[k]     <= w_aIn[k];
                r_b[k]     <= w_bIn[k];
                r_carry[k] <= w_chunk[k][CW];
                r_sum[k]   <= (k == LAST) ? w_sumFinal : w_sumNext[k];
                r_zero[k]  <= (k == LAST) ? w_zeroFinal : w_zeroNext[k];
`ifdef ADDSUB_SAT_EN
                r_sat[k]   <= w_satIn[k];
`endif
            end
            r_ovf <= w_ovf;
        end
    end

    // Data registers are not reset, so outputs are masked until a valid result lands.
    assign out_valid = r_valid[LAST];
    assign out_sum   = out_valid ? r_sum[LAST] : '0;
    assign out_carry = out_valid && r_carry[LAST];
    assign out_ovf   = out_valid && r_ovf;
    assign out_zero  = out_valid && r_zero[LAST];
    assign out_neg   = out_valid && r_sum[LAST][WIDTH-1];

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub: arithmetic model with scoreboard plus literal vectors.
// Define ADDSUB_SAT_EN to also exercise saturation.
module tb_pipelined_add_sub;

    localparam int WIDTH  = 64;
    localparam int STAGES = 4;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic             sat;
        logic [WIDTH-1:0] sum;
        logic [3:0]       flags;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic [3:0]       flags;
        int               accCyc;
        int               accStalls;
        bit               hasLit;
        logic [WIDTH-1:0] litSum;
        logic [3:0]       litFlags;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             inCin;
    logic             inSub;
    logic             inSat;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] outSum;
    logic             outCarry;
    logic             outOvf;
    logic             outZero;
    logic             outNeg;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   stalls = 0;
    exp_t expQ[$];
    vec_t vecs[$];
    vec_t pendVec;
    bit   pendHasLit = 1'b0;
    bit   prevStall  = 1'b0;
    logic [WIDTH-1:0] prevSum;
    logic [3:0]       prevFlags;

    pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (inValid),
        .in_ready (inReady),
        .in_a     (inA),
        .in_b     (inB),
        .in_cin   (inCin),
        .in_sub   (inSub),
`ifdef ADDSUB_SAT_EN
        .in_sat   (inSat),
`endif
        .out_valid(outValid),
        .out_ready(outReady),
        .out_sum  (outSum),
        .out_carry(outCarry),
        .out_ovf  (outOvf),
        .out_zero (outZero),
        .out_neg  (outNeg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkVal(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: exact signed arithmetic in WIDTH+2 bits, flags read off the true result.
    function automatic exp_t model(input vec_t v);
        exp_t             e;
        logic signed [WIDTH+1:0] sa, sb, sc, exact, maxS, minS;
        logic [WIDTH:0]   u;
        logic             carry, ovf;
        logic [WIDTH-1:0] sum;
        sa   = {{2{v.a[WIDTH-1]}}, v.a};
        sb   = {{2{v.b[WIDTH-1]}}, v.b};
        sc   = {{(WIDTH+1){1'b0}}, v.cin};
        maxS = {3'b000, {(WIDTH-1){1'b1}}};
        minS = {3'b111, {(WIDTH-1){1'b0}}};
        if (v.sub) begin
            exact = sa - sb;
            carry = (v.a >= v.b);
        end else begin
            exact = sa + sb + sc;
            u     = {1'b0, v.a} + {1'b0, v.b} + {{WIDTH{1'b0}}, v.cin};
            carry = u[WIDTH];
        end
        ovf = (exact > maxS) || (exact < minS);
        sum = exact[WIDTH-1:0];
        if (v.sat && ovf) sum = (exact > maxS) ? maxS[WIDTH-1:0] : minS[WIDTH-1:0];
        e.sum       = sum;
        e.flags     = {carry, ovf, (sum == '0), sum[WIDTH-1]};
        e.accCyc    = 0;
        e.accStalls = 0;
        e.hasLit    = 1'b0;
        e.litSum    = '0;
        e.litFlags  = '0;
        return e;
    endfunction

    function automatic vec_t mkVec(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub, input logic sat,
                                   input logic [WIDTH-1:0] sum, input logic [3:0] flags);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.sat = sat; v.sum = sum; v.flags = flags;
        return v;
    endfunction

    function automatic vec_t rndVec();
        vec_t v;
        v = mkVec({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)),
                  1'($urandom_range(1)), 1'b0, '0, '0);
        return v;
    endfunction

    // Scoreboard: in_ready rule, in-order results vs model, latency, stall hold, no stale results.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n !== 1'b1) begin
            expQ.delete();
            prevStall = 1'b0;
        end else begin
            checkVal("in_ready", 64'(inReady), 64'(!outValid || outReady));
            if (outValid) begin
                if (prevStall) begin
                    checkVal("stall_hold_sum", outSum, prevSum);
                    checkVal("stall_hold_flags", 64'({outCarry, outOvf, outZero, outNeg}), 64'(prevFlags));
                end
                if (expQ.size() == 0) begin
                    checkVal("stale_result", 64'(outValid), 64'(0));
                end else if (outReady) begin
                    e = expQ.pop_front();
                    checkVal("sum", outSum, e.sum);
                    checkVal("flags", 64'({outCarry, outOvf, outZero, outNeg}), 64'(e.flags));
                    checkVal("latency", 64'(cyc - e.accCyc), 64'(STAGES + stalls - e.accStalls));
                    if (e.hasLit) begin
                        checkVal("lit_sum", outSum, e.litSum);
                        checkVal("lit_flags", 64'({outCarry, outOvf, outZero, outNeg}), 64'(e.litFlags));
                    end
                end
            end
            if (inValid && inReady) begin
                e = model(mkVec(inA, inB, inCin, inSub, inSat, '0, '0));
                e.accCyc    = cyc;
                e.accStalls = stalls;
                e.hasLit    = pendHasLit;
                e.litSum    = pendVec.sum;
                e.litFlags  = pendVec.flags;
                expQ.push_back(e);
            end
            prevStall = outValid && !outReady;
            prevSum   = outSum;
            prevFlags = {outCarry, outOvf, outZero, outNeg};
            if (prevStall) stalls++;
        end
    end

    task automatic applyStimulus(input vec_t v, input bit hasLit);
        bit accepted;
        accepted   = 1'b0;
        pendVec    = v;
        pendHasLit = hasLit;
        inA = v.a; inB = v.b; inCin = v.cin; inSub = v.sub; inSat = v.sat;
        inValid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (inReady) begin
                accepted = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkVal("accept", 64'(accepted), 64'(1));
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, "_valid"}, 64'(outValid), 64'(0));
        checkVal({tag, "_sum"}, outSum, 64'(0));
        checkVal({tag, "_flags"}, 64'({outCarry, outOvf, outZero, outNeg}), 64'(0));
        checkVal({tag, "_in_ready"}, 64'(inReady), 64'(1));
    endtask

    task automatic waitEmpty();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !outValid) break;
        end
        checkVal("drain", 64'(expQ.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // flags literal order: {carry, ovf, zero, neg}
        vecs.push_back(mkVec(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, 64'h0, 4'b1010));
        vecs.push_back(mkVec(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1100));
        vecs.push_back(mkVec(64'h5, 64'h7, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0001));
        vecs.push_back(mkVec(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 4'b0000));
        vecs.push_back(mkVec(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 4'b0000));
        vecs.push_back(mkVec(64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 4'b0000));
        vecs.push_back(mkVec(64'h1, 64'h2, 1'b1, 1'b0, 1'b0, 64'h4, 4'b0000));
        vecs.push_back(mkVec(64'd10, 64'd3, 1'b1, 1'b1, 1'b0, 64'd7, 4'b1000));
        vecs.push_back(mkVec(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 4'b0101));
        vecs.push_back(mkVec(64'h3, 64'h3, 1'b0, 1'b1, 1'b0, 64'h0, 4'b1010));
        vecs.push_back(mkVec(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 64'h0, 4'b1110));
`ifdef ADDSUB_SAT_EN
        vecs.push_back(mkVec(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0100));
        vecs.push_back(mkVec(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 4'b1101));
        vecs.push_back(mkVec(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 4'b1101));
`endif

        rst_n = 1'b0; outReady = 1'b1; inValid = 1'b0;
        inA = '0; inB = '0; inCin = 1'b0; inSub = 1'b0; inSat = 1'b0;
        pendVec = mkVec('0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        idle(2);
        checkOutput("reset");
        rst_n = 1'b1;

        $display("[TB] directed vectors with a bubble");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i], 1'b1);
            if (i == 5) idle(2);
        end
        waitEmpty();

        $display("[TB] back-to-back random ops");
        for (int i = 0; i < 8; i++) applyStimulus(rndVec(), 1'b0);
        waitEmpty();

        $display("[TB] stall with a full pipe");
        fork
            begin
                for (int i = 0; i < 10; i++) applyStimulus(rndVec(), 1'b0);
            end
            begin
                idle(6);
                outReady = 1'b0;
                @(negedge clk);
                checkVal("stall_in_ready", 64'(inReady), 64'(0));
                idle(3);
                outReady = 1'b1;
            end
        join
        waitEmpty();

        $display("[TB] reset with ops in flight");
        for (int i = 0; i < 3; i++) applyStimulus(rndVec(), 1'b0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        checkOutput("flush");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkVal("no_stale_valid", 64'(outValid), 64'(0));
        end
        @(posedge clk);
        #1;
        applyStimulus(vecs[0], 1'b1);
        waitEmpty();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
